// File: rtl/uart_defs_pkg.sv
// ----------------------------------------------------------------------------
// uart_defs_pkg
//   Shared UART definitions used by the receive side (and the transmit side):
//   default bit timing for 50 MHz / 9600 baud and the 2-bit receiver FSM
//   state encoding.
// ----------------------------------------------------------------------------
package uart_defs_pkg;

    localparam int BPS_DIV_DEF = 5208;   // clk cycles per bit
    localparam int BPS_MID_DEF = 2604;   // count value where a bit is sampled

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

endpackage : uart_defs_pkg

// File: rtl/rx_bps_module.sv
// ----------------------------------------------------------------------------
// rx_bps_module
//   Bit timer for the UART receiver. Counts 0..BPS_DIV-1 while a frame is in
//   progress and emits a one-cycle strobe at mid-bit.
// Ports
//   CLK       in   system clock
//   RSTn      in   asynchronous active-low reset
//   Count_Sig in   high while the receiver is in START/DATA/STOP
//   BPS_CLK   out  1-cycle sample strobe when count == BPS_MID
// ----------------------------------------------------------------------------
module rx_bps_module
    import uart_defs_pkg::*;
#(
    parameter int BPS_DIV = BPS_DIV_DEF,
    parameter int BPS_MID = BPS_MID_DEF
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Count_Sig,
    output logic BPS_CLK
);

    localparam int CW = $clog2(BPS_DIV);

    logic [CW-1:0] count;

    // Held at 0 whenever the receiver is idle, so every frame starts its
    // timing from zero on entry to START.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            count <= '0;
        end else if (!Count_Sig) begin
            count <= '0;
        end else if (count == CW'(BPS_DIV - 1)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign BPS_CLK = Count_Sig && (count == CW'(BPS_MID));

endmodule : rx_bps_module

// File: rtl/rx_control_module.sv
// ----------------------------------------------------------------------------
// rx_control_module
//   Line synchroniser, start-edge detector, receive FSM, shift register and
//   registered outputs of the UART receiver (8N1, LSB first).
// Ports
//   CLK         in   system clock
//   RSTn        in   asynchronous active-low reset
//   RX_En_Sig   in   receive enable; low aborts any frame in progress
//   RX_Pin_In   in   serial line, idle high, asynchronous
//   BPS_CLK     in   mid-bit sample strobe from the bit timer
//   Count_Sig   out  high while a frame is in progress (runs the bit timer)
//   RX_Data     out  last correctly framed byte
//   RX_Done_Sig out  1-cycle pulse: RX_Data updated
//   RX_Err_Sig  out  1-cycle pulse: framing error (stop bit sampled low)
//   Dbg_State   out  current FSM state
// ----------------------------------------------------------------------------
module rx_control_module
    import uart_defs_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_En_Sig,
    input  logic       RX_Pin_In,
    input  logic       BPS_CLK,
    output logic       Count_Sig,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Err_Sig,
    output rx_state_e  Dbg_State
);

    logic      sync1, sync2, hist;
    logic      fall;
    rx_state_e state;
    logic [2:0] bit_idx;
    logic [7:0] shift;

    // hist is the previous synchronised sample; a 1->0 step is a start edge.
    // Reset to 1 so the line is treated as idle and no edge is seen at reset.
    assign fall = hist & ~sync2;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            hist        <= 1'b1;
            state       <= ST_IDLE;
            bit_idx     <= 3'd0;
            shift       <= 8'h00;
            RX_Data     <= 8'h00;
            RX_Done_Sig <= 1'b0;
            RX_Err_Sig  <= 1'b0;
        end else begin
            sync1       <= RX_Pin_In;
            sync2       <= sync1;
            hist        <= sync2;
            RX_Done_Sig <= 1'b0;
            RX_Err_Sig  <= 1'b0;

            if (state != ST_IDLE && !RX_En_Sig) begin
                // Abort: drop the partial frame silently.
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (fall && RX_En_Sig) begin
                            state <= ST_START;
                        end
                    end
                    ST_START: begin
                        if (BPS_CLK) begin
                            if (!sync2) begin
                                state   <= ST_DATA;
                                bit_idx <= 3'd0;
                            end else begin
                                state <= ST_IDLE;   // glitch / false start
                            end
                        end
                    end
                    ST_DATA: begin
                        if (BPS_CLK) begin
                            shift[bit_idx] <= sync2;
                            if (bit_idx == 3'd7) begin
                                state <= ST_STOP;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    ST_STOP: begin
                        // Leaving at mid-stop leaves half a bit to catch a
                        // back-to-back start edge.
                        if (BPS_CLK) begin
                            if (sync2) begin
                                RX_Data     <= shift;
                                RX_Done_Sig <= 1'b1;
                            end else begin
                                RX_Err_Sig  <= 1'b1;
                            end
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign Count_Sig = (state != ST_IDLE);
    assign Dbg_State = state;

endmodule : rx_control_module

// File: rtl/rx_module.sv
// ----------------------------------------------------------------------------
// rx_module
//   UART receiver top level (8N1). Instantiates the bit timer and the control
//   path.
// Ports
//   CLK         in   system clock
//   RSTn        in   asynchronous active-low reset
//   RX_En_Sig   in   receive enable; 0 ignores the line / aborts a frame
//   RX_Pin_In   in   serial line, idle high, asynchronous
//   RX_Data     out  last correctly framed byte, held until the next one
//   RX_Done_Sig out  1-cycle pulse when RX_Data is updated
//   RX_Err_Sig  out  1-cycle pulse on a framing error
//   dbg_state   out  receiver FSM state (uart_defs_pkg::rx_state_e encoding)
// ----------------------------------------------------------------------------
module rx_module
    import uart_defs_pkg::*;
#(
    parameter int BPS_DIV = BPS_DIV_DEF,
    parameter int BPS_MID = BPS_MID_DEF
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_En_Sig,
    input  logic       RX_Pin_In,
    output logic [7:0] RX_Data,
    output logic       RX_Done_Sig,
    output logic       RX_Err_Sig,
    output logic [1:0] dbg_state
);

    logic      count_sig;
    logic      bps_clk;
    rx_state_e state;

    rx_bps_module #(
        .BPS_DIV (BPS_DIV),
        .BPS_MID (BPS_MID)
    ) u_bps (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .Count_Sig (count_sig),
        .BPS_CLK   (bps_clk)
    );

    rx_control_module u_ctrl (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_En_Sig   (RX_En_Sig),
        .RX_Pin_In   (RX_Pin_In),
        .BPS_CLK     (bps_clk),
        .Count_Sig   (count_sig),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .RX_Err_Sig  (RX_Err_Sig),
        .Dbg_State   (state)
    );

    assign dbg_state = state;

endmodule : rx_module

// File: tb/tb_rx_module.sv
// ----------------------------------------------------------------------------
// tb_rx_module
//   Self-checking bench for rx_module at 16 clk/bit. Frames are driven onto
//   the line by a driver task; the reference model decides per frame whether
//   a done (with the byte) or an err pulse is owed and queues it; a monitor
//   pops the queue on every pulse.
// ----------------------------------------------------------------------------
module tb_rx_module;
    import uart_defs_pkg::*;

    localparam int DIV = 16;
    localparam int MID = 8;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_En_Sig = 1'b1;
    logic       RX_Pin_In = 1'b1;
    logic [7:0] RX_Data;
    logic       RX_Done_Sig;
    logic       RX_Err_Sig;
    logic [1:0] dbg_state;

    rx_module #(.BPS_DIV(DIV), .BPS_MID(MID)) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .RX_En_Sig   (RX_En_Sig),
        .RX_Pin_In   (RX_Pin_In),
        .RX_Data     (RX_Data),
        .RX_Done_Sig (RX_Done_Sig),
        .RX_Err_Sig  (RX_Err_Sig),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    // Each entry: {is_err, byte}
    logic [8:0]  exp_q[$];
    logic [7:0]  exp_data = 8'h00;
    int unsigned last_pulse_cyc = 0;
    int unsigned pulse_count = 0;
    int unsigned frame_start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge CLK) begin
        if (RSTn && (RX_Done_Sig || RX_Err_Sig)) begin
            logic [8:0] e;
            check("done_err_exclusive", {31'd0, RX_Done_Sig && RX_Err_Sig}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, RX_Done_Sig, RX_Err_Sig}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_err", {31'd0, RX_Err_Sig}, {31'd0, e[8]});
                if (RX_Done_Sig) check("rx_data_on_done", {24'd0, RX_Data}, {24'd0, e[7:0]});
            end
            last_pulse_cyc = cyc;
            pulse_count++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        RX_Pin_In = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drives one 8N1 frame. drop_at / rst_at: cycle index within the frame
    // at which enable is dropped / reset asserted (-1 = never). The model
    // owes a pulse only for frames that run to completion while enabled.
    task automatic send_frame(input logic [7:0] b, input logic stop_b,
                              input int drop_at, input int rst_at);
        logic [9:0] bits;
        bit aborted;
        bits = {stop_b, b, 1'b0};
        aborted = 0;
        if (RX_En_Sig && drop_at < 0 && rst_at < 0) begin
            exp_q.push_back({~stop_b, b});
            if (stop_b) exp_data = b;
        end
        frame_start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            for (int c = 0; c < DIV; c++) begin
                if (!aborted) begin
                    if (i * DIV + c == drop_at) RX_En_Sig = 1'b0;
                    if (i * DIV + c == rst_at) begin
                        RSTn = 1'b0;
                        aborted = 1;
                        exp_q.delete();
                        exp_data = 8'h00;
                        RX_Pin_In = 1'b1;
                    end else begin
                        RX_Pin_In = bits[i];
                    end
                    @(posedge CLK);
                    #1;
                end
            end
        end
        if (aborted) begin
            repeat (3) @(posedge CLK);
            #1;
            check("reset_mid_frame_data", {24'd0, RX_Data}, 32'd0);
            check("reset_mid_frame_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
            RSTn = 1'b1;
        end
        if (drop_at >= 0) begin
            idle(20);
            RX_En_Sig = 1'b1;
        end
    endtask

    task automatic expect_drained(input string tag);
        check(tag, exp_q.size(), 32'd0);
        check({tag, "_data"}, {24'd0, RX_Data}, {24'd0, exp_data});
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int unsigned pc;
        logic        prev_stop;

        // reset state
        RSTn = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("reset_data", {24'd0, RX_Data}, 32'd0);
        check("reset_done", {31'd0, RX_Done_Sig}, 32'd0);
        check("reset_err", {31'd0, RX_Err_Sig}, 32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        RSTn = 1'b1;
        idle(20);

        // 1: single good frame, latency ~9.5 bits + sync
        send_frame(8'hA5, 1'b1, -1, -1);
        idle(4);
        expect_drained("t1_a5");
        check("t1_latency_window",
              {31'd0, (last_pulse_cyc - frame_start_cyc) inside {[150:162]}}, 32'd1);

        // 2: short low glitch is rejected, following frame is good
        pc = pulse_count;
        RX_Pin_In = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        idle(40);
        check("t2_glitch_no_pulse", pulse_count, pc);
        check("t2_glitch_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(4);
        expect_drained("t2_3c");

        // 3: framing error keeps old data; then a break (line held low)
        send_frame(8'h5A, 1'b1, -1, -1);
        send_frame(8'h3C, 1'b0, -1, -1);
        pc = pulse_count;
        RX_Pin_In = 1'b0;
        repeat (60) @(posedge CLK);
        #1;
        check("t3_break_no_pulse", pulse_count, pc);
        idle(20);
        expect_drained("t3_err");

        // 4: back-to-back frames
        send_frame(8'h00, 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        idle(4);
        expect_drained("t4_b2b");

        // 5: reset during data bit 4 of C3, then 81
        send_frame(8'hC3, 1'b1, -1, 5 * DIV + MID);
        idle(60);
        expect_drained("t5_after_reset");
        send_frame(8'h81, 1'b1, -1, -1);
        idle(4);
        expect_drained("t5_81");

        // 6: disabled for the whole frame, then dropped mid-frame
        pc = pulse_count;
        RX_En_Sig = 1'b0;
        send_frame(8'h77, 1'b1, -1, -1);
        idle(10);
        RX_En_Sig = 1'b1;
        idle(10);
        send_frame(8'h77, 1'b1, 4 * DIV + 3, -1);
        check("t6_no_pulse", pulse_count, pc);
        check("t6_state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        expect_drained("t6_77");

        // random frames: random byte, stop bit, gaps, glitches, enable drops
        prev_stop = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int unsigned gap;
            logic [7:0]  b;
            logic        sb;
            gap = $urandom_range(0, 30);
            if (!prev_stop && gap < 2) gap = 2;
            if (gap > 0) idle(gap);
            if ($urandom_range(0, 7) == 0) begin
                RX_Pin_In = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge CLK);
                #1;
                idle(30);
            end
            b  = 8'($urandom);
            sb = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) begin
                send_frame(b, sb, $urandom_range(20, 140), -1);
                prev_stop = 1'b1;
            end else begin
                send_frame(b, sb, -1, -1);
                prev_stop = sb;
            end
        end
        idle(40);
        expect_drained("random_end");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_rx_module
